pipeline_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32IM_Zbb pipeline. It keeps its own shadow record of the instructions in EX, MEM and WB. From these records it produces the forwarding selects, the PC and IF/ID enables, the IF/ID flush, the ID/EX bubble request and the next-PC select for branches resolved in ID. It also stalls the front end and EX for multi-cycle DIV/REM operations.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/hazard_fwd_unit.sv | 61 ++++++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
//   FWD_REG/FWD_WB/FWD_MEM : EX operand forward-select encodings
//   stage_rec_t            : shadow record of one pipeline stage
//   md_state_t             : multi-cycle DIV/REM sequencer states
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_we;
    logic       mem_read;
    logic       md;
  } stage_rec_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A record can supply a forwarded value for register rs.
  function automatic logic fwd_src(input stage_rec_t r, input logic [4:0] rs);
    return r.valid && r.rd_we && (r.rd != 5'd0) && (r.rd == rs);
  endfunction

  // A load in this record will write register rs (value not yet available).
  function automatic logic load_dst(input stage_rec_t r, input logic [4:0] rs);
    return r.valid && r.mem_read && (r.rd != 5'd0) && (r.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational register comparators for the hazard controller.
// Inputs : ID record plus its source-use and branch flags, EX/MEM/WB records.
// Outputs: EX operand forward selects, ID branch forward selects, and a raw
//          stall request (load-use or branch dependency). Priority against
//          the divider hold is resolved by the caller.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  stage_rec_t id_rec_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       id_branch_i,
  input  stage_rec_t ex_rec_i,
  input  stage_rec_t mem_rec_i,
  input  stage_rec_t wb_rec_i,
  output logic [1:0] alu_forward_a_o,
  output logic [1:0] alu_forward_b_o,
  output logic       branch_forward_a_o,
  output logic       branch_forward_b_o,
  output logic       stall_req_o
);

  logic use1;
  logic use2;
  logic load_use;
  logic branch_dep;

  always_comb begin
    // MEM is the younger producer, so it is checked first.
    alu_forward_a_o = FWD_REG;
    if (fwd_src(mem_rec_i, ex_rec_i.rs1))     alu_forward_a_o = FWD_MEM;
    else if (fwd_src(wb_rec_i, ex_rec_i.rs1)) alu_forward_a_o = FWD_WB;

    alu_forward_b_o = FWD_REG;
    if (fwd_src(mem_rec_i, ex_rec_i.rs2))     alu_forward_b_o = FWD_MEM;
    else if (fwd_src(wb_rec_i, ex_rec_i.rs2)) alu_forward_b_o = FWD_WB;

    // A load in MEM has no result yet, so it cannot feed the ID comparator.
    branch_forward_a_o = id_branch_i && fwd_src(mem_rec_i, id_rec_i.rs1) && !mem_rec_i.mem_read;
    branch_forward_b_o = id_branch_i && fwd_src(mem_rec_i, id_rec_i.rs2) && !mem_rec_i.mem_read;

    use1 = id_rec_i.valid && id_uses_rs1_i;
    use2 = id_rec_i.valid && id_uses_rs2_i;

    load_use = (use1 && load_dst(ex_rec_i, id_rec_i.rs1)) ||
               (use2 && load_dst(ex_rec_i, id_rec_i.rs2));

    // Branches resolve in ID, so any EX result and any MEM load are too late.
    branch_dep = id_branch_i &&
                 ((use1 && (fwd_src(ex_rec_i, id_rec_i.rs1) || load_dst(mem_rec_i, id_rec_i.rs1))) ||
                  (use2 && (fwd_src(ex_rec_i, id_rec_i.rs2) || load_dst(mem_rec_i, id_rec_i.rs2))));

    stall_req_o = load_use || branch_dep;
  end

  logic unused_bits;
  assign unused_bits = ^{ex_rec_i.md, mem_rec_i.rs1, mem_rec_i.rs2, mem_rec_i.md,
                         wb_rec_i.rs1, wb_rec_i.rs2, wb_rec_i.mem_read, wb_rec_i.md,
                         id_rec_i.rd, id_rec_i.rd_we, id_rec_i.mem_read, id_rec_i.md};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline.
// Keeps shadow records of EX/MEM/WB, drives forwarding selects, PC and IF/ID
// enables, IF/ID flush, ID/EX bubble, next-PC select for ID-resolved branches,
// and a DIV/REM sequencer that freezes EX for DIV_CYCLES cycles.
// Handshake: md_start_o pulses the first cycle a DIV/REM sits in EX;
// md_done_o pulses on its last EX cycle, when ex_hold_o drops and it moves on.
// Ports: clk, rst (async, active-high), id_* instruction fields,
// branch_condition_i; outputs listed in the port list below.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_rd_we_i,
  input  logic       id_mem_read_i,
  input  logic       id_branch_i,
  input  logic       id_md_op_i,
  input  logic       branch_condition_i,
  output logic [1:0] alu_forward_a_o,
  output logic [1:0] alu_forward_b_o,
  output logic       branch_forward_a_o,
  output logic       branch_forward_b_o,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       if_id_flush_o,
  output logic       id_ex_bubble_o,
  output logic       ex_hold_o,
  output logic       pc_next_sel_o,
  output logic       md_start_o,
  output logic       md_done_o
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 2);

  stage_rec_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  stage_rec_t id_rec;
  md_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hold;
  logic stall_req;
  logic stall;
  logic taken;
  logic md_start;
  logic md_done;

  always_comb begin
    id_rec.valid    = id_valid_i;
    id_rec.rs1      = id_rs1_i;
    id_rec.rs2      = id_rs2_i;
    id_rec.rd       = id_rd_i;
    id_rec.rd_we    = id_rd_we_i;
    id_rec.mem_read = id_mem_read_i;
    id_rec.md       = id_md_op_i;
  end

  hazard_fwd_unit u_hazard_fwd (
    .id_rec_i          (id_rec),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .id_branch_i       (id_branch_i),
    .ex_rec_i          (ex_q),
    .mem_rec_i         (mem_q),
    .wb_rec_i          (wb_q),
    .alu_forward_a_o   (alu_forward_a_o),
    .alu_forward_b_o   (alu_forward_b_o),
    .branch_forward_a_o(branch_forward_a_o),
    .branch_forward_b_o(branch_forward_b_o),
    .stall_req_o       (stall_req)
  );

  // DIV/REM sequencer: the counter starts at DIV_CYCLES-2 so that hold spans
  // DIV_CYCLES-1 cycles and the done cycle is the DIV_CYCLES-th in EX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold     = 1'b0;
    md_start = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (ex_q.valid && ex_q.md) begin
          md_start = 1'b1;
          hold     = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          hold  = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Hold beats stall beats taken branch.
  always_comb begin
    stall = stall_req && !hold;
    taken = id_valid_i && id_branch_i && branch_condition_i && !stall && !hold;

    wb_d = mem_q;
    if (hold) begin
      ex_d  = ex_q;
      mem_d = '0;
    end else begin
      ex_d  = stall ? '0 : id_rec;
      mem_d = ex_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_en_o        = !(hold || stall);
  assign if_id_en_o     = !(hold || stall);
  assign id_ex_bubble_o = stall;
  assign ex_hold_o      = hold;
  assign pc_next_sel_o  = taken;
  assign if_id_flush_o  = taken;
  assign md_start_o     = md_start;
  assign md_done_o      = md_done;

endmodule
